// File: rtl/serial_word_comp.sv
// Bit-serial WIDTH-bit magnitude comparator, MSB- or LSB-first, unsigned or two's complement.
// Result valid with a one-cycle done pulse one cycle after the last accepted bit; no backpressure, gaps via bit_valid.
module serial_word_comp #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic msb_first,
   input  logic is_signed,
   input  logic bit_valid,
   input  logic serial_a,
   input  logic serial_b,
   output logic busy,
   output logic done,
   output logic g,
   output logic e,
   output logic s
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          msb_q, msb_n;
   logic          sgn_q, sgn_n;
   logic          g_n, e_n, s_n;
   logic          busy_n, done_n;

   logic          accept;
   logic          last_bit;
   logic          sign_pos;
   logic          differ;
   logic          a_gt_b;

   assign accept   = (state == SHIFT) && bit_valid && !start;
   assign last_bit = (cnt == CW'(WIDTH - 1));
   // The sign bit is the first bit seen in MSB-first order and the last in LSB-first order.
   assign sign_pos = msb_q ? (cnt == '0) : last_bit;
   assign differ   = serial_a ^ serial_b;
   assign a_gt_b   = (serial_a & ~serial_b) ^ (sgn_q & sign_pos);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         msb_q <= 1'b0;
         sgn_q <= 1'b0;
         g     <= 1'b0;
         e     <= 1'b1;
         s     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         msb_q <= msb_n;
         sgn_q <= sgn_n;
         g     <= g_n;
         e     <= e_n;
         s     <= s_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      if (start) begin
         state_n = SHIFT;
      end else if (accept && last_bit) begin
         state_n = IDLE;
      end
   end

   always_comb begin
      cnt_n  = cnt;
      msb_n  = msb_q;
      sgn_n  = sgn_q;
      g_n    = g;
      e_n    = e;
      s_n    = s;
      busy_n = busy;
      done_n = 1'b0;
      if (start) begin
         cnt_n  = '0;
         msb_n  = msb_first;
         sgn_n  = is_signed;
         g_n    = 1'b0;
         e_n    = 1'b1;
         s_n    = 1'b0;
         busy_n = 1'b1;
      end else if (accept) begin
         cnt_n = cnt + CW'(1);
         // MSB-first locks on the first difference (e still set); LSB-first lets later differences overwrite.
         if (differ && (!msb_q || e)) begin
            g_n = a_gt_b;
            e_n = 1'b0;
            s_n = ~a_gt_b;
         end
         if (last_bit) begin
            done_n = 1'b1;
            busy_n = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_comp.sv
// Directed bench for serial_word_comp (WIDTH=8) with a result scoreboard checked on done.
module tb_serial_word_comp;

   logic clk = 1'b0;
   logic rst, start, msb_first, is_signed, bit_valid, serial_a, serial_b;
   logic busy, done, g, e, s;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int exp_dones = 0;
   logic [2:0] exp_q[$];
   logic [2:0] last_gse;

   always #5 clk = ~clk;

   serial_word_comp #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .msb_first(msb_first),
      .is_signed(is_signed), .bit_valid(bit_valid), .serial_a(serial_a),
      .serial_b(serial_b), .busy(busy), .done(done), .g(g), .e(e), .s(s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b, input logic sgn);
      logic gt, lt;
      if (sgn) begin
         gt = $signed(a) > $signed(b);
         lt = $signed(a) < $signed(b);
      end else begin
         gt = a > b;
         lt = a < b;
      end
      return {gt, !(gt || lt), lt};
   endfunction

   // Scoreboard: each done pops one expected result.
   always @(negedge clk) begin
      if (rst && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            check("sb_gse", {g, e, s}, exp_q.pop_front());
         end
      end
   end

   task automatic drive_start(input logic msb, input logic sgn, input logic bv, input logic a, input logic b);
      start = 1'b1; msb_first = msb; is_signed = sgn;
      bit_valid = bv; serial_a = a; serial_b = b;
      @(posedge clk); #1;
      start = 1'b0; bit_valid = 1'b0;
      msb_first = 1'($urandom); is_signed = 1'($urandom);
      check("busy_after_start", busy, 1);
      check("gse_after_start", {g, e, s}, 3'b010);
      check("done_after_start", done, 0);
   endtask

   task automatic drive_bit(input logic a, input logic b, input logic last);
      bit_valid = 1'b1; serial_a = a; serial_b = b;
      @(posedge clk); #1;
      bit_valid = 1'b0; serial_a = 1'($urandom); serial_b = 1'($urandom);
      msb_first = 1'($urandom); is_signed = 1'($urandom);
      if (!last) begin
         check("busy_mid_word", busy, 1);
         check("done_mid_word", done, 0);
      end
   endtask

   task automatic gap_cycle();
      bit_valid = 1'b0; serial_a = 1'($urandom); serial_b = 1'($urandom);
      @(posedge clk); #1;
      check("done_in_gap", done, 0);
      check("busy_in_gap", busy, 1);
   endtask

   task automatic finish_word(input logic [2:0] exp);
      check("done_pulse", done, 1);
      check("busy_at_done", busy, 0);
      exp_dones++;
      last_gse = exp;
      @(negedge clk); #1;
      check("done_count", done_cnt, exp_dones);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("gse_held", {g, e, s}, last_gse);
   endtask

   task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic msb,
                            input logic sgn, input logic [7:0] gaps);
      logic [2:0] exp;
      int idx;
      exp = model(a, b, sgn);
      exp_q.push_back(exp);
      drive_start(msb, sgn, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         idx = msb ? 7 - i : i;
         drive_bit(a[idx], b[idx], i == 7);
         if (i < 7 && gaps[i]) gap_cycle();
      end
      finish_word(exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ra, rb;
      rst = 1'b0; start = 1'b0; msb_first = 1'b0; is_signed = 1'b0;
      bit_valid = 1'b0; serial_a = 1'b0; serial_b = 1'b0;

      // Reset with random inputs toggling, including start.
      for (int i = 0; i < 2; i++) begin
         start = 1'($urandom); bit_valid = 1'($urandom);
         serial_a = 1'($urandom); serial_b = 1'($urandom);
         msb_first = 1'($urandom); is_signed = 1'($urandom);
         @(posedge clk); #1;
      end
      check("reset_gse", {g, e, s}, 3'b010);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst = 1'b1; start = 1'b0;

      // bit_valid in IDLE is ignored.
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1; serial_a = 1'b1; serial_b = 1'b0;
         @(posedge clk); #1;
         check("idle_gse", {g, e, s}, 3'b010);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
      end
      bit_valid = 1'b0;

      send_word(8'hA5, 8'hA3, 1'b1, 1'b0, 8'h00);
      // Result held through idle cycles with stray bits.
      for (int i = 0; i < 2; i++) begin
         bit_valid = 1'b1; serial_a = 1'b0; serial_b = 1'b1;
         @(posedge clk); #1;
         check("hold_gse", {g, e, s}, 3'b100);
      end
      bit_valid = 1'b0;

      // Gaps after the 2nd and 5th bits.
      send_word(8'h01, 8'h80, 1'b0, 1'b0, 8'b0001_0010);
      check("lsb_unsigned_s", {g, e, s}, 3'b001);
      send_word(8'h80, 8'h7F, 1'b1, 1'b1, 8'h00);
      check("msb_signed_s", {g, e, s}, 3'b001);
      send_word(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00);
      check("lsb_signed_s", {g, e, s}, 3'b001);
      send_word(8'h5A, 8'h5A, 1'b1, 1'b1, 8'h00);
      check("eq_msb", {g, e, s}, 3'b010);
      send_word(8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00);
      check("eq_lsb", {g, e, s}, 3'b010);
      send_word(8'h7F, 8'h80, 1'b0, 1'b0, 8'h00);
      check("lsb_unsigned_small", {g, e, s}, 3'b001);

      // Restart: the aborted word yields no done, the bit in the restart cycle is dropped.
      drive_start(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 1'b0);
      exp_q.push_back(3'b001);
      drive_start(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      ra = 8'h10; rb = 8'h20;
      for (int i = 7; i >= 0; i--) drive_bit(ra[i], rb[i], i == 0);
      finish_word(3'b001);

      // Reset mid-word.
      drive_start(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_gse", {g, e, s}, 3'b010);
      for (int i = 0; i < 10; i++) begin
         bit_valid = 1'($urandom); serial_a = 1'($urandom); serial_b = 1'($urandom);
         @(posedge clk); #1;
      end
      bit_valid = 1'b0;
      check("midrst_no_done", done_cnt, exp_dones);
      check("midrst_gse_idle", {g, e, s}, 3'b010);
      send_word(8'h33, 8'hC3, 1'b1, 1'b1, 8'h00);

      // Random words, modes and gaps.
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom); rb = (i % 3 == 0) ? ra : 8'($urandom);
         send_word(ra, rb, 1'($urandom), 1'($urandom), 8'($urandom) & 8'h7F);
      end

      check("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_word_comp.md
# serial_word_comp

Parametrised bit-serial magnitude comparator for WIDTH-bit words, the successor to the single-bit cascade serial comparator. It accepts two operands one bit per valid cycle, in either MSB-first or LSB-first order, with unsigned or two's-complement interpretation selected per word. It frames each word with a start pulse, counts bits, and reports greater/equal/smaller together with a one-cycle done pulse. It sits after serial receivers that feed the datapath's comparison and sorting logic.

## Interface

- WIDTH, 8, operand word length in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- start  input  1  begin a new word; samples msb_first and is_signed
- msb_first  input  1  1 = bits arrive MSB first; 0 = LSB first
- is_signed  input  1  1 = two's-complement compare; 0 = unsigned
- bit_valid  input  1  serial_a/serial_b carry a valid bit this cycle
- serial_a  input  1  operand A bit
- serial_b  input  1  operand B bit
- busy  output  1  word in progress; bits are being accepted
- done  output  1  one-cycle pulse: final result present on g/e/s
- g  output  1  A > B
- e  output  1  A == B
- s  output  1  A < B

## Operation

- FSM: IDLE, SHIFT. All state and all outputs are registered.
- Reset (rst=0 at an edge): state=IDLE, bit counter=0, g=0, e=1, s=0, busy=0, done=0. Reset overrides every other input.
- IDLE: bit_valid is ignored. start=1 latches the mode bits, sets counter=0, g/e/s=0/1/0 and busy=1, and moves to SHIFT.
- SHIFT: each bit_valid=1 cycle consumes one bit pair and increments the counter. Cycles with bit_valid=0 are gaps: no state change.
- Update rules, with index = bit position of the pair in its word:
  - MSB-first: the first differing pair decides, and later bits are ignored. For that pair, a=1,b=0 gives g and a=0,b=1 gives s. If is_signed and the pair is bit WIDTH-1 (the first bit), the sense is inverted.
  - LSB-first: every differing pair overwrites the result (a=1,b=0 gives g; a=0,b=1 gives s), so the last difference wins. If is_signed and the pair is bit WIDTH-1 (the last bit), the sense is inverted. Equal pairs leave the result unchanged.
- g/e/s are always exactly one-hot. During SHIFT they show the running result, which is meaningful only at done.
- When the WIDTH-th bit is accepted: done=1 for the next cycle, busy=0, state=IDLE. g/e/s then hold the final result until the next start or reset.
- start in SHIFT aborts the word and restarts immediately, with the same effects as start in IDLE. No done is produced for the aborted word.
- start and bit_valid in the same cycle: start wins and the bit is discarded.
- The bit counter is clog2(WIDTH)+1 bits wide. Terminal count is WIDTH-1 on an accepted bit, so there is no wrap-around.

## Timing

- start sampled at edge T0 gives busy=1 from T0 onward.
- With no gaps, bits are sampled at edges T1..TWIDTH. done is high for the single cycle following edge TWIDTH, and busy falls at that same edge.
- Minimum latency: WIDTH+1 cycles from start to done. Each gap cycle adds one.
- A new start is legal in the same cycle that done is high. The result on g/e/s is cleared at that edge, so it must be captured while done=1.
- The mode inputs matter only at the start edge. Changing them mid-word has no effect.

## Test plan

- Reset: rst=0 for 2 cycles with random inputs -> g=0, e=1, s=0, busy=0, done=0. bit_valid pulses in IDLE leave these unchanged.
- WIDTH=8, unsigned, MSB-first, A=0xA5, B=0xA3, no gaps -> done in cycle 9 after start, g=1, e=0, s=0. Result held until the next start.
- Unsigned, LSB-first, A=0x01, B=0x80, with a bit_valid=0 gap after bits 2 and 5 -> done 11 cycles after start, s=1.
- Signed compares:
  - MSB-first, A=0x80, B=0x7F -> s=1.
  - LSB-first, A=0xFF, B=0x01 -> s=1.
  - A=B=0x5A in both orders -> e=1.
- Restart: start, 3 bits of A=0xFF/B=0x00, then start again (with bit_valid=1 in that cycle) and 8 bits of A=0x10, B=0x20 -> exactly one done pulse, s=1. The bit in the restart cycle is discarded.
- Reset mid-word: start, 4 bits, rst=0 for one cycle -> busy=0, done never pulses, g/e/s=0/1/0. A following full word compares correctly.
